// File: rtl/strip_alloc.sv
// strip_alloc: places items into the first ROM-suggested strip that has room, tracking per-strip fill.
// Define STRIP_ALLOC_STATS_EN to add the alloc_cnt/fail_cnt outputs.
module strip_alloc #(
    parameter int NUM_STRIPS = 15,
    parameter int STRIP_CAP  = 64,
    parameter int WIDTH_W    = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [4:0]         req_height,
    input  logic [WIDTH_W-1:0] req_width,
    input  logic               clear,
    output logic               rom_en,
    output logic [3:0]         rom_addr,
    input  logic [3:0]         rom_id1,
    input  logic [3:0]         rom_id2,
    input  logic [3:0]         rom_id3,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [3:0]         res_strip,
    output logic [WIDTH_W-1:0] res_offset,
    output logic               res_fail
`ifdef STRIP_ALLOC_STATS_EN
    ,
    output logic [15:0]        alloc_cnt,
    output logic [15:0]        fail_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, LOOKUP, CHECK, RESP} state_t;

    state_t             state, state_nx;
    logic [1:0]         k;
    logic [WIDTH_W-1:0] width;
    logic [WIDTH_W-1:0] fill [NUM_STRIPS];
    logic [3:0]         cand;
    logic               in_range, fit, accept, bad_req, wipe;
    logic [WIDTH_W-1:0] cand_fill;
    logic [WIDTH_W:0]   sum;

    assign req_ready = state == IDLE && !clear;
    assign accept    = req_valid && req_ready;
    assign wipe      = state == IDLE && clear;
    assign bad_req   = req_height < 5'd4 || req_height > 5'd16 || req_width == '0;
    assign rom_en    = state == LOOKUP;
    assign res_valid = state == RESP;
    assign cand      = k == 2'd0 ? rom_id1 : k == 2'd1 ? rom_id2 : rom_id3;
    assign in_range  = cand != 4'hF && 32'(cand) < NUM_STRIPS;
    assign cand_fill = in_range ? fill[cand] : '0;
    // one extra bit so a full strip plus any width cannot wrap into a false fit
    assign sum       = {1'b0, cand_fill} + {1'b0, width};
    assign fit       = state == CHECK && in_range && sum <= (WIDTH_W+1)'(STRIP_CAP);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (bad_req ? RESP : LOOKUP) : IDLE;
            LOOKUP:  state_nx = CHECK;
            CHECK:   state_nx = (fit || k == 2'd2) ? RESP : CHECK;
            RESP:    state_nx = res_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k          <= '0;
            width      <= '0;
            rom_addr   <= '0;
            res_strip  <= 4'hF;
            res_offset <= '0;
            res_fail   <= 1'b0;
            for (int i = 0; i < NUM_STRIPS; i++) fill[i] <= '0;
        end else begin
            if (wipe)
                for (int i = 0; i < NUM_STRIPS; i++) fill[i] <= '0;
            if (accept) begin
                width <= req_width;
                if (bad_req) begin
                    res_strip  <= 4'hF;
                    res_offset <= '0;
                    res_fail   <= 1'b1;
                end else
                    rom_addr <= req_height <= 5'd12 ? 4'(req_height - 5'd4) : 4'd9;
            end
            if (state == LOOKUP) k <= '0;
            if (state == CHECK) begin
                if (fit) begin
                    res_strip  <= cand;
                    res_offset <= cand_fill;
                    res_fail   <= 1'b0;
                    fill[cand] <= sum[WIDTH_W-1:0];
                end else if (k == 2'd2) begin
                    res_strip  <= 4'hF;
                    res_offset <= '0;
                    res_fail   <= 1'b1;
                end else
                    k <= k + 2'd1;
            end
        end
    end

`ifdef STRIP_ALLOC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_cnt <= '0;
            fail_cnt  <= '0;
        end else if (wipe) begin
            alloc_cnt <= '0;
            fail_cnt  <= '0;
        end else if (res_valid && res_ready) begin
            if (!res_fail && alloc_cnt != 16'hFFFF) alloc_cnt <= alloc_cnt + 16'd1;
            if (res_fail && fail_cnt != 16'hFFFF)   fail_cnt  <= fail_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_strip_alloc.sv
// tb_strip_alloc: directed scoreboard bench for strip_alloc with a behavioural strip-ID ROM.
module tb_strip_alloc;
    logic       clk = 0, rst_n = 0;
    logic       req_valid = 0, req_ready, clear = 0;
    logic [4:0] req_height = 0;
    logic [6:0] req_width = 0;
    logic       rom_en;
    logic [3:0] rom_addr, rom_id1 = 4'hF, rom_id2 = 4'hF, rom_id3 = 4'hF;
    logic       res_valid, res_ready = 1, res_fail;
    logic [3:0] res_strip;
    logic [6:0] res_offset;
`ifdef STRIP_ALLOC_STATS_EN
    logic [15:0] alloc_cnt, fail_cnt;
`endif

    int checks = 0, errors = 0;

    typedef struct {
        logic [3:0] s;
        logic [6:0] o;
        logic       f;
        int         lat;
        int         roms;
        logic [3:0] addr;
    } exp_t;
    exp_t exp_q[$];

    strip_alloc dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_height(req_height), .req_width(req_width), .clear(clear),
        .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_id1(rom_id1), .rom_id2(rom_id2), .rom_id3(rom_id3),
        .res_valid(res_valid), .res_ready(res_ready), .res_strip(res_strip),
        .res_offset(res_offset), .res_fail(res_fail)
`ifdef STRIP_ALLOC_STATS_EN
        , .alloc_cnt(alloc_cnt), .fail_cnt(fail_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_lookup(input logic [3:0] a);
        return a == 4'd4 ? 12'h012 : a == 4'd0 ? 12'h97F : {a, 8'hFF};
    endfunction

    always @(posedge clk)
        if (rom_en) {rom_id1, rom_id2, rom_id3} <= rom_lookup(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic [4:0] h, input logic [6:0] w, input logic [3:0] es,
                           input logic [6:0] eo, input logic ef, input int elat, input bit hold);
        exp_t e;
        int   n = 0, roms = 0;
        bit   seen = 0;
        e.s = es; e.o = eo; e.f = ef; e.lat = elat;
        e.roms = (elat == 0) ? 0 : 1;
        e.addr = h <= 5'd12 ? 4'(h - 5'd4) : 4'd9;
        exp_q.push_back(e);
        @(negedge clk);
        res_ready = !hold;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_height = h; req_width = w;
        @(posedge clk);
        #1 req_valid = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (rom_en) begin
                roms++;
                chk("rom_addr", rom_addr, exp_q[0].addr);
            end
            if (res_valid) seen = 1;
            else n++;
        end
        e = exp_q.pop_front();
        if (!seen) begin
            chk("timeout", 0, 1);
            return;
        end
        chk("latency", n, e.lat);
        chk("res_strip", res_strip, e.s);
        chk("res_offset", res_offset, e.o);
        chk("res_fail", res_fail, e.f);
        chk("rom_en_pulses", roms, e.roms);
        if (hold) begin
            repeat (5) begin
                @(negedge clk);
                chk("hold_valid", res_valid, 1);
                chk("hold_strip", res_strip, e.s);
                chk("hold_offset", res_offset, e.o);
                chk("hold_req_ready", req_ready, 0);
            end
            res_ready = 1;
        end
        @(posedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_res_valid", res_valid, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_strip", res_strip, 4'hF);
        chk("rst_res_offset", res_offset, 0);
        chk("rst_res_fail", res_fail, 0);
        chk("rst_req_ready", req_ready, 1);
        run_req(8, 10, 0, 0, 0, 2, 0);
        run_req(8, 10, 0, 10, 0, 2, 0);
        run_req(8, 40, 0, 20, 0, 2, 0);
        run_req(8, 10, 1, 0, 0, 3, 0);
        run_req(8, 4, 0, 60, 0, 2, 0);
        run_req(13, 64, 9, 0, 0, 2, 0);
        run_req(11, 64, 7, 0, 0, 2, 0);
        run_req(4, 1, 4'hF, 0, 1, 4, 0);
        run_req(13, 1, 4'hF, 0, 1, 4, 0);
        run_req(3, 5, 4'hF, 0, 1, 0, 0);
        run_req(17, 5, 4'hF, 0, 1, 0, 0);
        run_req(8, 0, 4'hF, 0, 1, 0, 0);
        run_req(8, 1, 1, 10, 0, 3, 1);
        @(negedge clk);
        clear = 1;
        #1 chk("clear_req_ready", req_ready, 0);
        @(negedge clk);
        clear = 0;
        run_req(12, 64, 8, 0, 0, 2, 0);
        run_req(8, 10, 0, 0, 0, 2, 0);
        @(negedge clk);
        req_valid = 1; req_height = 8; req_width = 10;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("abort_res_valid", res_valid, 0);
        chk("abort_rom_en", rom_en, 0);
        chk("abort_res_strip", res_strip, 4'hF);
        chk("abort_res_offset", res_offset, 0);
        chk("abort_res_fail", res_fail, 0);
        chk("abort_rom_addr", rom_addr, 0);
        @(negedge clk);
        rst_n = 1;
        run_req(8, 10, 0, 0, 0, 2, 0);
`ifdef STRIP_ALLOC_STATS_EN
        @(negedge clk);
        chk("alloc_cnt", alloc_cnt, 1);
        chk("fail_cnt", fail_cnt, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
